uart_mmio_ctrl: RTL

Memory-mapped controller that sits between the PCH bus decode and UART_TxRx, and sequences the UART for the core. CPU stores to TX_DATA are queued in a small FIFO. A TX state machine drains the FIFO one byte at a time: it presents the byte, pulses send_tx, and tracks uart_busy. Received bytes are captured into a holding register with status and error flags, and the UART ready flag is acknowledged automatically.

---
 rtl/uart_mmio_ctrl.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl
//   Memory-mapped front end for UART_TxRx. CPU stores to TX_DATA are queued in
//   a small FIFO and drained one byte at a time by the TX state machine.
//   Received bytes are latched into a holding register, and the UART ready
//   flag is acknowledged automatically.
//
// Register map (word address match on haddr[31:2]):
//   BASE+0  TX_DATA  W: push hwdata[7:0]           R: 0
//   BASE+4  RX_DATA  R: {24'b0, rx_hold}; a read with re=1 consumes the byte
//   BASE+8  STATUS   R: {26'b0, rx_overrun, tx_overflow, rx_valid,
//                        uart_busy, tx_empty, tx_full}
//                    W: bit4 clears tx_overflow, bit5 clears rx_overrun,
//                       bit8 sets tx_ie
//
// Ports:
//   clk, reset         system clock, asynchronous active-high reset
//   haddr, hwdata      bus address / write data
//   we, re             bus write / read strobes
//   hrdata             combinational read data, 0 when unmapped
//   tx_data, send_tx   byte and one-cycle start pulse to the UART
//   uart_busy          UART transmitter busy
//   rx_data, rx_ready  UART receive byte and ready level
//   rx_ack             one-cycle pulse that clears the UART ready flag
//   irq                rx_valid, or TX FIFO empty while tx_ie is set
//
// TX FSM:
//   state      | meaning
//   IDLE       | wait for a queued byte; pop it into tx_data
//   LOAD       | one cycle so tx_data is stable ahead of the start pulse
//   SEND       | send_tx high for this cycle; arm the busy timeout
//   WAIT_BUSY  | wait for uart_busy to rise, give up after BUSY_TIMEOUT cycles
//   WAIT_DONE  | wait for uart_busy to fall
module uart_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0040,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          BUSY_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] hrdata,
  output logic [7:0]  tx_data,
  output logic        send_tx,
  input  logic        uart_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        rx_ack,
  output logic        irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  localparam logic [29:0]   TX_WORD = BASE_ADDR[31:2];
  localparam logic [29:0]   RX_WORD = TX_WORD + 30'd1;
  localparam logic [29:0]   ST_WORD = TX_WORD + 30'd2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMR_TOP = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [TW-1:0] tmr_q;
  logic          pop, tmr_load, tmr_dec;
  logic          push_req, push_ok;
  logic          tx_empty, tx_full;
  logic          tx_overflow, tx_ie;
  logic          rx_ready_q, rx_rise, rx_rd;
  logic [7:0]    rx_hold;
  logic          rx_valid, rx_overrun;
  logic          sel_tx, sel_rx, sel_st, st_wr;
  logic          unused_bits;

  // Byte lanes below the word address and the upper write-data bits carry
  // nothing for this block.
  assign unused_bits = ^{haddr[1:0], hwdata[31:9]};

  assign sel_tx = (haddr[31:2] == TX_WORD);
  assign sel_rx = (haddr[31:2] == RX_WORD);
  assign sel_st = (haddr[31:2] == ST_WORD);
  assign st_wr  = we & sel_st;
  assign rx_rd  = re & sel_rx;

  assign tx_empty = (count_q == '0);
  assign tx_full  = (count_q == DEPTH_C);

  // A push into a full FIFO still lands if the FSM frees a slot this cycle.
  assign push_req = we & sel_tx;
  assign push_ok  = push_req & ((count_q < DEPTH_C) | pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= hwdata[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          pop     = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_SEND;
      S_SEND: begin
        tmr_load = 1'b1;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (uart_busy)          state_d = S_WAIT_DONE;
        else if (tmr_q == '0)   state_d = S_IDLE;
        else                    tmr_dec = 1'b1;
      end
      S_WAIT_DONE: begin
        if (!uart_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded from the state register so a reset removes the pulse at once.
  assign send_tx = (state_q == S_SEND);

  // The busy timeout counts down from BUSY_TIMEOUT-1, giving BUSY_TIMEOUT
  // cycles in WAIT_BUSY before the byte is treated as sent.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tx_data <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) tx_data <= fifo_mem[rd_ptr_q];
      if (tmr_load)     tmr_q <= TMR_TOP;
      else if (tmr_dec) tmr_q <= tmr_q - TW'(1);
    end
  end

  // A dropped push wins over a same-cycle clear so the event is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_overflow <= 1'b0;
      tx_ie       <= 1'b0;
    end else begin
      if (push_req && !push_ok)    tx_overflow <= 1'b1;
      else if (st_wr && hwdata[4]) tx_overflow <= 1'b0;
      if (st_wr && hwdata[8])      tx_ie <= 1'b1;
    end
  end

  assign rx_rise = rx_ready & ~rx_ready_q;

  // A capture that coincides with an RX_DATA read replaces the byte being
  // consumed, so rx_valid stays set and no overrun is recorded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ready_q <= 1'b0;
      rx_ack     <= 1'b0;
      rx_hold    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;
      rx_ack     <= rx_rise;
      if (rx_rise) begin
        rx_hold  <= rx_data;
        rx_valid <= 1'b1;
      end else if (rx_rd) begin
        rx_valid <= 1'b0;
      end
      if (rx_rise && rx_valid && !rx_rd) rx_overrun <= 1'b1;
      else if (st_wr && hwdata[5])       rx_overrun <= 1'b0;
    end
  end

  always_comb begin
    hrdata = '0;
    if (sel_rx)
      hrdata = {24'b0, rx_hold};
    else if (sel_st)
      hrdata = {26'b0, rx_overrun, tx_overflow, rx_valid, uart_busy, tx_empty, tx_full};
  end

  assign irq = rx_valid | (tx_empty & tx_ie);

endmodule
